// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the data-cache tag compare block:
//   - default cache geometry (used when the including build does not supply it)
//   - tag-compare FSM state encoding
//   - bit positions of the fields inside one tag entry {valid, dirty, tag, blank}
// Optional feature macro used by the block: TAG_CMP_STATS_EN.
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 6
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 22
`endif
`ifndef BLANK_WIDTH
`define BLANK_WIDTH 8
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 32
`endif

package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_RHIT    = 3'd2,
        S_RMISS   = 3'd3,
        S_WHIT    = 3'd4,
        S_WMISS   = 3'd5
    } state_t;

    // Field positions inside a tag entry laid out as {valid, dirty, tag, blank}.
    localparam int VALID_BIT = `TAG_SIZE - 1;
    localparam int DIRTY_BIT = `TAG_SIZE - 2;
    localparam int TAG_MSB   = `BLANK_WIDTH + `TAG_WIDTH - 1;
    localparam int TAG_LSB   = `BLANK_WIDTH;

endpackage

// File: rtl/tag_way_match.sv
// -----------------------------------------------------------------------------
// tag_way_match
// Combinational decode of one memory response beat {tag entry, line data}:
// extracts valid/dirty/tag/data and flags a hit when the entry is valid and
// its tag equals the request tag.
// Ports:
//   beat      : one way's tag entry and line data
//   req_tag   : tag field of the pending request address
//   way_valid, way_dirty, way_tag, way_data : extracted fields
//   way_hit   : valid && tag match
// -----------------------------------------------------------------------------
module tag_way_match
    import dcache_pkg::*;
#(
    parameter int TAG_SIZE   = `TAG_SIZE,
    parameter int TAG_WIDTH  = `TAG_WIDTH,
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int VALID_POS  = VALID_BIT,
    parameter int DIRTY_POS  = DIRTY_BIT,
    parameter int TAG_HI     = TAG_MSB,
    parameter int TAG_LO     = TAG_LSB
) (
    input  logic [TAG_SIZE+DATA_WIDTH-1:0] beat,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    output logic                           way_valid,
    output logic                           way_dirty,
    output logic [TAG_WIDTH-1:0]           way_tag,
    output logic [DATA_WIDTH-1:0]          way_data,
    output logic                           way_hit
);

    logic [TAG_SIZE-1:0] entry;
    logic                unused_blank;

    assign entry        = beat[TAG_SIZE+DATA_WIDTH-1:DATA_WIDTH];
    assign way_data     = beat[DATA_WIDTH-1:0];
    assign way_valid    = entry[VALID_POS];
    assign way_dirty    = entry[DIRTY_POS];
    assign way_tag      = entry[TAG_HI:TAG_LO];
    assign way_hit      = way_valid && (way_tag == req_tag);
    // The blank padding carries no information.
    assign unused_blank = ^entry[TAG_LO-1:0];

endmodule

// File: rtl/tag_compare_assoc.sv
// -----------------------------------------------------------------------------
// tag_compare_assoc
// Set-associative tag compare for the data cache. A request {wr, tid, addr} is
// popped from the request FIFO, the NUM_WAYS tag entries of the set arrive one
// way per beat, and the block resolves hit/miss:
//   read hit   -> ROB write {tid, data}
//   read miss  -> AR request, plus AW/W writeback of a dirty round-robin victim
//   write hit  -> pull write-buffer data, fill into the hit way
//   write miss -> pull write-buffer data, fill into the victim way, with
//                 AW/W writeback in the same cycle as the fill handshake
// Victim: lowest invalid way (no writeback), else rr_ptr (writeback iff dirty).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   rdata_i/rvalid_i/rready_o       : tag+data beats, one way per beat
//   req_*                           : request FIFO read side
//   wbuf_*                          : write-buffer read side
//   rob_*, ar_*, aw_*, w_*          : output FIFO write sides
//   fill_*                          : fill handshake {addr(MSB=1), data} + way
// Optional (macro TAG_CMP_STATS_EN): hit_cnt_o / miss_cnt_o saturating counters.
// -----------------------------------------------------------------------------
module tag_compare_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int TID_WIDTH    = `TID_WIDTH,
    parameter int TAG_SIZE     = `TAG_SIZE,
    parameter int TAG_WIDTH    = `TAG_WIDTH,
    parameter int BLANK_WIDTH  = `BLANK_WIDTH,
    parameter int INDEX_WIDTH  = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
    parameter int NUM_WAYS     = 4,
    localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [TAG_SIZE+DATA_WIDTH-1:0]  rdata_i,
    input  logic                            rvalid_i,
    output logic                            rready_o,
    input  logic                            req_aempty_i,
    output logic                            req_rden_o,
    input  logic [TID_WIDTH+ADDR_WIDTH:0]   req_data_i,
    input  logic                            wbuf_aempty_i,
    output logic                            wbuf_rden_o,
    input  logic [DATA_WIDTH-1:0]           wbuf_data_i,
    input  logic                            rob_afull_i,
    output logic                            rob_wren_o,
    output logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_o,
    input  logic                            ar_afull_i,
    output logic                            ar_wren_o,
    output logic [TID_WIDTH+ADDR_WIDTH-1:0] ar_data_o,
    input  logic                            aw_afull_i,
    output logic                            aw_wren_o,
    output logic [ADDR_WIDTH-1:0]           aw_data_o,
    input  logic                            w_afull_i,
    output logic                            w_wren_o,
    output logic [DATA_WIDTH-1:0]           w_data_o,
    input  logic                            fill_ready_i,
    output logic                            fill_valid_o,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_o,
    output logic [WAY_W-1:0]                fill_way_o
`ifdef TAG_CMP_STATS_EN
    ,
    output logic [31:0]                     hit_cnt_o,
    output logic [31:0]                     miss_cnt_o
`endif
);

    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

    state_t                  state, state_nxt;
    logic [WAY_W-1:0]        beat_cnt;
    logic [WAY_W-1:0]        rr_ptr;

    logic                    req_wr;
    logic [TID_WIDTH-1:0]    req_tid;
    logic [ADDR_WIDTH-1:0]   req_addr;

    logic                    hit_found;
    logic [WAY_W-1:0]        hit_way;
    logic [DATA_WIDTH-1:0]   hit_data;
    logic                    inv_found;
    logic [WAY_W-1:0]        inv_way;
    logic [TAG_WIDTH-1:0]    rr_tag;
    logic                    rr_dirty;
    logic [DATA_WIDTH-1:0]   rr_data;

    logic                    fill_pend;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_q;

    logic                    b_valid, b_dirty, b_hit;
    logic [TAG_WIDTH-1:0]    b_tag;
    logic [DATA_WIDTH-1:0]   b_data;

    logic                    beat_fire, last_beat, hit_now;
    logic                    wb_needed, wb_room;
    logic [WAY_W-1:0]        victim_way;

    logic                    rready, req_rden, wbuf_rden, rob_wren;
    logic                    ar_wren, aw_wren, w_wren, fill_valid, retire;

    tag_way_match #(
        .TAG_SIZE   (TAG_SIZE),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .VALID_POS  (TAG_SIZE - 1),
        .DIRTY_POS  (TAG_SIZE - 2),
        .TAG_HI     (BLANK_WIDTH + TAG_WIDTH - 1),
        .TAG_LO     (BLANK_WIDTH)
    ) u_match (
        .beat      (rdata_i),
        .req_tag   (req_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH]),
        .way_valid (b_valid),
        .way_dirty (b_dirty),
        .way_tag   (b_tag),
        .way_data  (b_data),
        .way_hit   (b_hit)
    );

    assign beat_fire  = (state == S_COLLECT) && rvalid_i;
    assign last_beat  = beat_fire && (beat_cnt == LAST_WAY);
    // A hit on the final beat has not reached hit_found yet.
    assign hit_now    = hit_found || b_hit;
    // Only the round-robin way can need a writeback; an invalid way is free.
    assign wb_needed  = !inv_found && rr_dirty;
    assign wb_room    = !aw_afull_i && !w_afull_i;
    assign victim_way = inv_found ? inv_way : rr_ptr;

    // ---- next state / handshake decode ----
    always_comb begin
        state_nxt  = state;
        rready     = 1'b0;
        req_rden   = 1'b0;
        wbuf_rden  = 1'b0;
        rob_wren   = 1'b0;
        ar_wren    = 1'b0;
        aw_wren    = 1'b0;
        w_wren     = 1'b0;
        fill_valid = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!req_aempty_i) begin
                    req_rden  = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                rready = 1'b1;
                if (last_beat) begin
                    if (req_wr) state_nxt = hit_now ? S_WHIT : S_WMISS;
                    else        state_nxt = hit_now ? S_RHIT : S_RMISS;
                end
            end
            S_RHIT: begin
                if (!rob_afull_i) begin
                    rob_wren  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RMISS: begin
                if (!ar_afull_i && (!wb_needed || wb_room)) begin
                    ar_wren   = 1'b1;
                    aw_wren   = wb_needed;
                    w_wren    = wb_needed;
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WHIT, S_WMISS: begin
                if (!fill_pend) begin
                    wbuf_rden = !wbuf_aempty_i;
                end else if (state == S_WHIT) begin
                    fill_valid = 1'b1;
                    if (fill_ready_i) state_nxt = S_IDLE;
                end else if (!wb_needed || wb_room) begin
                    // Fill is only offered when the writeback can go out with it.
                    fill_valid = 1'b1;
                    if (fill_ready_i) begin
                        aw_wren   = wb_needed;
                        w_wren    = wb_needed;
                        retire    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- state and datapath registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            rr_ptr      <= '0;
            req_wr      <= 1'b0;
            req_tid     <= '0;
            req_addr    <= '0;
            hit_found   <= 1'b0;
            hit_way     <= '0;
            hit_data    <= '0;
            inv_found   <= 1'b0;
            inv_way     <= '0;
            rr_tag      <= '0;
            rr_dirty    <= 1'b0;
            rr_data     <= '0;
            fill_pend   <= 1'b0;
            fill_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (req_rden) begin
                {req_wr, req_tid, req_addr} <= req_data_i;
                beat_cnt  <= '0;
                hit_found <= 1'b0;
                inv_found <= 1'b0;
                fill_pend <= 1'b0;
            end
            if (beat_fire) begin
                beat_cnt <= beat_cnt + WAY_W'(1);
                if (b_hit && !hit_found) begin
                    hit_found <= 1'b1;
                    hit_way   <= beat_cnt;
                    hit_data  <= b_data;
                end
                if (!b_valid && !inv_found) begin
                    inv_found <= 1'b1;
                    inv_way   <= beat_cnt;
                end
                if (beat_cnt == rr_ptr) begin
                    rr_tag   <= b_tag;
                    rr_dirty <= b_dirty;
                    rr_data  <= b_data;
                end
            end
            if (wbuf_rden) begin
                fill_pend   <= 1'b1;
                fill_data_q <= {1'b1, req_addr[ADDR_WIDTH-2:0], wbuf_data_i};
            end
            // Advance only when the round-robin way was actually evicted.
            if (retire && !inv_found) begin
                rr_ptr <= (rr_ptr == LAST_WAY) ? '0 : rr_ptr + WAY_W'(1);
            end
        end
    end

    assign rready_o     = rst_n & rready;
    assign req_rden_o   = rst_n & req_rden;
    assign wbuf_rden_o  = rst_n & wbuf_rden;
    assign rob_wren_o   = rst_n & rob_wren;
    assign ar_wren_o    = rst_n & ar_wren;
    assign aw_wren_o    = rst_n & aw_wren;
    assign w_wren_o     = rst_n & w_wren;
    assign fill_valid_o = rst_n & fill_valid;

    assign rob_data_o   = {req_tid, hit_data};
    assign ar_data_o    = {req_tid, req_addr};
    assign aw_data_o    = {rr_tag, req_addr[INDEX_WIDTH+OFFSET_WIDTH-1:0]};
    assign w_data_o     = rr_data;
    assign fill_data_o  = fill_data_q;
    assign fill_way_o   = (state == S_WHIT) ? hit_way : victim_way;

`ifdef TAG_CMP_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (last_beat) begin
            if (hit_now) hit_cnt  <= sat_inc(hit_cnt);
            else         miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`endif

endmodule

// File: tb/tb_tag_compare_assoc.sv
// -----------------------------------------------------------------------------
// tb_tag_compare_assoc
// Directed bench for tag_compare_assoc with NUM_WAYS=4, 32-bit address/data,
// 4-bit tid, 6-bit index, 4-bit offset, 22-bit tag, 8-bit blank.
// Inputs are driven 1 time unit after the rising edge; outputs are checked on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_tag_compare_assoc;

    localparam int AW = 32, DW = 32, TW = 4, TS = 32, TGW = 22, BW = 8;
    localparam int IW = 6, OW = 4, NW = 4, WW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [TS+DW-1:0]   rdata_i;
    logic               rvalid_i;
    logic               rready_o;
    logic               req_aempty_i;
    logic               req_rden_o;
    logic [TW+AW:0]     req_data_i;
    logic               wbuf_aempty_i;
    logic               wbuf_rden_o;
    logic [DW-1:0]      wbuf_data_i;
    logic               rob_afull_i;
    logic               rob_wren_o;
    logic [TW+DW-1:0]   rob_data_o;
    logic               ar_afull_i;
    logic               ar_wren_o;
    logic [TW+AW-1:0]   ar_data_o;
    logic               aw_afull_i;
    logic               aw_wren_o;
    logic [AW-1:0]      aw_data_o;
    logic               w_afull_i;
    logic               w_wren_o;
    logic [DW-1:0]      w_data_o;
    logic               fill_ready_i;
    logic               fill_valid_o;
    logic [AW+DW-1:0]   fill_data_o;
    logic [WW-1:0]      fill_way_o;
`ifdef TAG_CMP_STATS_EN
    logic [31:0]        hit_cnt_o, miss_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tag_compare_assoc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TID_WIDTH(TW), .TAG_SIZE(TS),
        .TAG_WIDTH(TGW), .BLANK_WIDTH(BW), .INDEX_WIDTH(IW),
        .OFFSET_WIDTH(OW), .NUM_WAYS(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .req_aempty_i(req_aempty_i), .req_rden_o(req_rden_o), .req_data_i(req_data_i),
        .wbuf_aempty_i(wbuf_aempty_i), .wbuf_rden_o(wbuf_rden_o), .wbuf_data_i(wbuf_data_i),
        .rob_afull_i(rob_afull_i), .rob_wren_o(rob_wren_o), .rob_data_o(rob_data_o),
        .ar_afull_i(ar_afull_i), .ar_wren_o(ar_wren_o), .ar_data_o(ar_data_o),
        .aw_afull_i(aw_afull_i), .aw_wren_o(aw_wren_o), .aw_data_o(aw_data_o),
        .w_afull_i(w_afull_i), .w_wren_o(w_wren_o), .w_data_o(w_data_o),
        .fill_ready_i(fill_ready_i), .fill_valid_o(fill_valid_o),
        .fill_data_o(fill_data_o), .fill_way_o(fill_way_o)
`ifdef TAG_CMP_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    // Request address: tag 0x0ABCD, index 0x15, offset 0x3 -> 0x02AF3553
    logic [TGW-1:0] rt  = 22'h0ABCD;
    logic [IW-1:0]  idx = 6'h15;
    logic [OW-1:0]  off = 4'h3;
    logic [AW-1:0]  addr_v;
    logic [TGW-1:0] t1 = 22'h00111, t2 = 22'h00222, t3 = 22'h00333, t4 = 22'h00444;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bt(input logic v, input logic d,
                                       input logic [21:0] tg, input logic [31:0] dt);
        return {v, d, tg, 8'h00, dt};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pop one request and leave the DUT in COLLECT waiting for beat 0.
    task automatic issue(input logic wr, input logic [3:0] tid);
        req_data_i   = {wr, tid, addr_v};
        req_aempty_i = 1'b0;
        @(negedge clk);
        chk("req_rden_pulse", req_rden_o, 1'b1);
        cyc();
        req_aempty_i = 1'b1;
        @(negedge clk);
        chk("rready_collect", rready_o, 1'b1);
        chk("req_rden_single", req_rden_o, 1'b0);
        cyc();
    endtask

    task automatic beats(input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            rdata_i  = b[i];
            rvalid_i = 1'b1;
            cyc();
        end
        rvalid_i = 1'b0;
        rdata_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_v        = {rt, idx, off};
        rst_n         = 1'b0;
        rdata_i       = '0;
        rvalid_i      = 1'b0;
        req_aempty_i  = 1'b0;
        req_data_i    = '0;
        wbuf_aempty_i = 1'b1;
        wbuf_data_i   = '0;
        rob_afull_i   = 1'b0;
        ar_afull_i    = 1'b0;
        aw_afull_i    = 1'b0;
        w_afull_i     = 1'b0;
        fill_ready_i  = 1'b0;

        // Reset: outputs quiet even with a non-empty request FIFO
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_req_rden", req_rden_o, 1'b0);
        chk("rst_rready", rready_o, 1'b0);
        chk("rst_rob_data", rob_data_o, '0);
        chk("rst_fill_data", fill_data_o, '0);
        chk("rst_fill_way", fill_way_o, '0);
        chk("rst_ar_wren", ar_wren_o, 1'b0);
`ifdef TAG_CMP_STATS_EN
        chk("rst_hit_cnt", hit_cnt_o, '0);
        chk("rst_miss_cnt", miss_cnt_o, '0);
`endif
        cyc();
        rst_n        = 1'b1;
        req_aempty_i = 1'b1;
        @(negedge clk);
        chk("idle_no_rden", req_rden_o, 1'b0);
        cyc();

        // T1: read hit on way 2 (way 3 also matches and must be ignored)
        rob_afull_i = 1'b1;
        issue(1'b0, 4'h5);
        beats(bt(1, 0, t1, 32'hCAFE0000), bt(1, 1, t2, 32'hCAFE0001),
              bt(1, 0, rt, 32'hCAFE0002), bt(1, 0, rt, 32'hCAFE0003));
        @(negedge clk);
        chk("t1_rready_drop", rready_o, 1'b0);
        chk("t1_rob_wren_afull", rob_wren_o, 1'b0);
        cyc();
        rob_afull_i = 1'b0;
        @(negedge clk);
        chk("t1_rob_wren", rob_wren_o, 1'b1);
        chk("t1_rob_data", rob_data_o, 36'h5CAFE0002);
        chk("t1_no_ar", ar_wren_o, 1'b0);
        cyc();
        @(negedge clk);
        chk("t1_rob_single", rob_wren_o, 1'b0);
        cyc();

        // T2: read miss, way 1 invalid (tag matches but invalid), others dirty
        ar_afull_i = 1'b1;
        issue(1'b0, 4'h6);
        beats(bt(1, 1, t1, 32'h0), bt(0, 1, rt, 32'h1),
              bt(1, 1, t3, 32'h2), bt(1, 1, t4, 32'h3));
        @(negedge clk);
        chk("t2_ar_wait", ar_wren_o, 1'b0);
        cyc();
        ar_afull_i = 1'b0;
        @(negedge clk);
        chk("t2_ar_wren", ar_wren_o, 1'b1);
        chk("t2_no_aw", aw_wren_o, 1'b0);
        chk("t2_no_w", w_wren_o, 1'b0);
        chk("t2_ar_data", ar_data_o, {4'h6, addr_v});
        cyc();
        @(negedge clk);
        chk("t2_ar_single", ar_wren_o, 1'b0);
        cyc();

        // T3: write miss, all valid & clean; victim = rr_ptr = 0 (untouched by T2)
        issue(1'b1, 4'h7);
        beats(bt(1, 0, t1, 32'hE0), bt(1, 0, t2, 32'hE1),
              bt(1, 0, t3, 32'hE2), bt(1, 0, t4, 32'hE3));
        @(negedge clk);
        chk("t3_fill_way", fill_way_o, 2'd0);
        chk("t3_rden_wait", wbuf_rden_o, 1'b0);
        cyc();
        wbuf_aempty_i = 1'b0;
        wbuf_data_i   = 32'h12345678;
        @(negedge clk);
        chk("t3_wbuf_rden", wbuf_rden_o, 1'b1);
        chk("t3_fill_not_yet", fill_valid_o, 1'b0);
        cyc();
        wbuf_aempty_i = 1'b1;
        fill_ready_i  = 1'b1;
        @(negedge clk);
        chk("t3_fill_valid", fill_valid_o, 1'b1);
        chk("t3_fill_data", fill_data_o, {1'b1, addr_v[30:0], 32'h12345678});
        chk("t3_no_aw", aw_wren_o, 1'b0);
        cyc();
        fill_ready_i = 1'b0;
        @(negedge clk);
        chk("t3_fill_done", fill_valid_o, 1'b0);
        cyc();

        // T4: read miss, rr_ptr = 1 clean, others dirty -> AR only
        issue(1'b0, 4'h8);
        beats(bt(1, 1, t1, 32'h0), bt(1, 0, t2, 32'h1),
              bt(1, 1, t3, 32'h2), bt(1, 1, t4, 32'h3));
        @(negedge clk);
        chk("t4_ar_wren", ar_wren_o, 1'b1);
        chk("t4_no_aw", aw_wren_o, 1'b0);
        chk("t4_no_w", w_wren_o, 1'b0);
        cyc();

        // T5: write miss, rr_ptr = 2 dirty, AW almost full blocks the fill
        aw_afull_i = 1'b1;
        issue(1'b1, 4'h3);
        beats(bt(1, 0, t1, 32'h0), bt(1, 0, t2, 32'h1),
              bt(1, 1, t3, 32'hD00D0002), bt(1, 0, t4, 32'h3));
        wbuf_aempty_i = 1'b0;
        wbuf_data_i   = 32'hAAAA5555;
        @(negedge clk);
        chk("t5_fill_way", fill_way_o, 2'd2);
        chk("t5_wbuf_rden", wbuf_rden_o, 1'b1);
        cyc();
        wbuf_aempty_i = 1'b1;
        fill_ready_i  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_fill_blocked", fill_valid_o, 1'b0);
            chk("t5_aw_blocked", aw_wren_o, 1'b0);
            cyc();
        end
        aw_afull_i = 1'b0;
        @(negedge clk);
        chk("t5_fill_valid", fill_valid_o, 1'b1);
        chk("t5_aw_wren", aw_wren_o, 1'b1);
        chk("t5_w_wren", w_wren_o, 1'b1);
        chk("t5_aw_data", aw_data_o, {t3, idx, off});
        chk("t5_w_data", w_data_o, 32'hD00D0002);
        cyc();
        fill_ready_i = 1'b0;
        @(negedge clk);
        chk("t5_aw_single", aw_wren_o, 1'b0);
        cyc();

        // T6: read miss, rr_ptr = 3 dirty -> AR/AW/W together, rr wraps
        issue(1'b0, 4'h4);
        beats(bt(1, 0, t1, 32'h0), bt(1, 1, t2, 32'h1),
              bt(1, 0, t3, 32'h2), bt(1, 1, t4, 32'hBEEF0003));
        @(negedge clk);
        chk("t6_ar_wren", ar_wren_o, 1'b1);
        chk("t6_aw_wren", aw_wren_o, 1'b1);
        chk("t6_w_wren", w_wren_o, 1'b1);
        chk("t6_aw_data", aw_data_o, {t4, idx, off});
        chk("t6_w_data", w_data_o, 32'hBEEF0003);
        chk("t6_ar_data", ar_data_o, {4'h4, addr_v});
        cyc();

        // T7: write miss all valid clean -> victim 0 shows rr_ptr wrapped
        issue(1'b1, 4'h2);
        beats(bt(1, 0, t1, 32'h0), bt(1, 0, t2, 32'h1),
              bt(1, 0, t3, 32'h2), bt(1, 0, t4, 32'h3));
        wbuf_aempty_i = 1'b0;
        wbuf_data_i   = 32'h55550000;
        @(negedge clk);
        chk("t7_fill_way_wrap", fill_way_o, 2'd0);
        cyc();
        wbuf_aempty_i = 1'b1;
        fill_ready_i  = 1'b1;
        @(negedge clk);
        chk("t7_fill_valid", fill_valid_o, 1'b1);
        cyc();
        fill_ready_i = 1'b0;

        // T8: write hit way 0 (rr_ptr now 1), write buffer empty for 5 cycles
        issue(1'b1, 4'h1);
        beats(bt(1, 0, rt, 32'h0), bt(1, 0, t2, 32'h1),
              bt(1, 0, rt, 32'h2), bt(1, 0, t4, 32'h3));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t8_rden_wait", wbuf_rden_o, 1'b0);
            cyc();
        end
        wbuf_aempty_i = 1'b0;
        wbuf_data_i   = 32'h0BADF00D;
        @(negedge clk);
        chk("t8_wbuf_rden", wbuf_rden_o, 1'b1);
        chk("t8_fill_way", fill_way_o, 2'd0);
        cyc();
        wbuf_aempty_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t8_fill_hold", fill_valid_o, 1'b1);
            chk("t8_fill_data", fill_data_o, {1'b1, addr_v[30:0], 32'h0BADF00D});
            chk("t8_rden_single", wbuf_rden_o, 1'b0);
            cyc();
        end
        fill_ready_i = 1'b1;
        @(negedge clk);
        chk("t8_fill_valid", fill_valid_o, 1'b1);
        cyc();
        fill_ready_i = 1'b0;
        @(negedge clk);
        chk("t8_fill_done", fill_valid_o, 1'b0);
`ifdef TAG_CMP_STATS_EN
        chk("t8_hit_cnt", hit_cnt_o, 32'd2);
        chk("t8_miss_cnt", miss_cnt_o, 32'd6);
`endif
        cyc();

        // T9: reset at beat 2 of 4 abandons the request
        issue(1'b0, 4'h9);
        rdata_i  = bt(1, 0, t1, 32'h0);
        rvalid_i = 1'b1;
        cyc();
        rdata_i  = bt(1, 0, t2, 32'h1);
        cyc();
        rdata_i  = bt(1, 0, rt, 32'h2);
        rst_n    = 1'b0;
        @(negedge clk);
        chk("t9_rready_rst", rready_o, 1'b0);
        cyc();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        @(negedge clk);
        chk("t9_no_rob", rob_wren_o, 1'b0);
        chk("t9_no_ar", ar_wren_o, 1'b0);
`ifdef TAG_CMP_STATS_EN
        chk("t9_hit_cnt_rst", hit_cnt_o, '0);
        chk("t9_miss_cnt_rst", miss_cnt_o, '0);
`endif
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t9_idle_rready", rready_o, 1'b0);
        chk("t9_idle_rob", rob_wren_o, 1'b0);
        cyc();

        // Next request starts from beat 0: write hit on way 1
        issue(1'b1, 4'hA);
        beats(bt(1, 0, t1, 32'h0), bt(1, 0, rt, 32'h1),
              bt(1, 0, t3, 32'h2), bt(1, 0, t4, 32'h3));
        wbuf_aempty_i = 1'b0;
        wbuf_data_i   = 32'h77778888;
        @(negedge clk);
        chk("t9_hit_way1", fill_way_o, 2'd1);
        cyc();
        wbuf_aempty_i = 1'b1;
        fill_ready_i  = 1'b1;
        @(negedge clk);
        chk("t9_fill_valid", fill_valid_o, 1'b1);
        cyc();
        fill_ready_i = 1'b0;

        // rr_ptr was 1 before reset; a clean all-valid miss must evict way 0
        issue(1'b1, 4'hB);
        beats(bt(1, 0, t1, 32'h0), bt(1, 0, t2, 32'h1),
              bt(1, 0, t3, 32'h2), bt(1, 0, t4, 32'h3));
        @(negedge clk);
        chk("t9_rr_reset", fill_way_o, 2'd0);
`ifdef TAG_CMP_STATS_EN
        chk("t9_hit_cnt", hit_cnt_o, 32'd1);
        chk("t9_miss_cnt", miss_cnt_o, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tag_compare_assoc.md
TAG_COMPARE_ASSOC -- requirements
Module: tag_compare_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `AXI_ADDR_WIDTH, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `AXI_DATA_WIDTH, cache line data width.
REQ-003 SHALL have parameter TID_WIDTH, default `TID_WIDTH, transaction id width.
REQ-004 SHALL have parameters TAG_SIZE, TAG_WIDTH, BLANK_WIDTH, INDEX_WIDTH and OFFSET_WIDTH, each defaulting to the same-named shared define; tag entry layout is {valid, dirty, tag, blank}.
REQ-005 SHALL have parameter NUM_WAYS, default 4, associativity; legal values are powers of 2 from 1 to 16; WAY_W = max(1, clog2(NUM_WAYS)).
REQ-006 SHALL have clock clk (input, 1 bit); all logic is rising-edge.
REQ-007 SHALL have reset rst_n (input, 1 bit), synchronous, active-low.
REQ-008 SHALL have the memory response ports rdata_i (input, TAG_SIZE+DATA_WIDTH, one way per beat), rvalid_i (input, 1) and rready_o (output, 1).
REQ-009 SHALL have the request FIFO ports req_aempty_i (input, 1), req_rden_o (output, 1) and req_data_i (input, 1+TID_WIDTH+ADDR_WIDTH, {wr, tid, addr}).
REQ-010 SHALL have the write buffer ports wbuf_aempty_i (input, 1), wbuf_rden_o (output, 1) and wbuf_data_i (input, DATA_WIDTH).
REQ-011 SHALL have the ROB ports rob_afull_i (input, 1), rob_wren_o (output, 1) and rob_data_o (output, TID_WIDTH+DATA_WIDTH, {tid, data}).
REQ-012 SHALL have the AR FIFO ports ar_afull_i (input, 1), ar_wren_o (output, 1) and ar_data_o (output, TID_WIDTH+ADDR_WIDTH, {tid, addr}).
REQ-013 SHALL have the AW FIFO ports aw_afull_i (input, 1), aw_wren_o (output, 1) and aw_data_o (output, ADDR_WIDTH, victim address).
REQ-014 SHALL have the W FIFO ports w_afull_i (input, 1), w_wren_o (output, 1) and w_data_o (output, DATA_WIDTH, victim data).
REQ-015 SHALL have the fill ports fill_ready_i (input, 1), fill_valid_o (output, 1), fill_data_o (output, ADDR_WIDTH+DATA_WIDTH, {addr, data}, with the addr MSB forced to 1 as the write flag) and fill_way_o (output, WAY_W).

Function
REQ-016 SHALL implement the states S_IDLE, S_COLLECT, S_RHIT, S_RMISS, S_WHIT and S_WMISS.
REQ-017 S_IDLE: when !req_aempty_i, SHALL pulse req_rden_o for 1 cycle, latch req_data_i, clear the beat counter and hit/invalid flags, then enter S_COLLECT.
REQ-018 S_COLLECT: SHALL drive rready_o=1; each rvalid_i cycle is one beat for way number beat_cnt, counting 0..NUM_WAYS-1.
REQ-019 Per beat: hit if valid && tag == addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH]; the first hit captures way and data, and later hits are ignored.
REQ-020 Per beat: SHALL record the lowest-numbered invalid way, and SHALL capture tag, dirty and data of the way equal to rr_ptr.
REQ-021 On the last beat (same cycle) SHALL resolve the state: read hit -> S_RHIT, read miss -> S_RMISS, write hit -> S_WHIT, write miss -> S_WMISS; rready_o drops the next cycle.
REQ-022 Victim SHALL be the lowest invalid way if any, with no writeback; otherwise it is rr_ptr, with writeback iff its dirty bit is 1.
REQ-023 rr_ptr SHALL increment modulo NUM_WAYS only when rr_ptr was chosen as victim and the miss retires.
REQ-024 Writeback address SHALL be {victim tag, request index, request offset}; writeback data is the victim data.
REQ-025 S_RHIT: SHALL drive rob_data_o={tid, hit data}; when !rob_afull_i, pulse rob_wren_o and return to S_IDLE.
REQ-026 S_RMISS: without writeback, SHALL wait for !ar_afull_i; with writeback, wait for !ar_afull_i && !aw_afull_i && !w_afull_i; then pulse all needed wren in one cycle, go to S_IDLE.
REQ-027 S_WHIT/S_WMISS entry SHALL wait for !wbuf_aempty_i, then pulse wbuf_rden_o once and latch wbuf_data_i into fill_data_o.
REQ-028 fill_way_o SHALL be the hit way (S_WHIT) or the victim way (S_WMISS).
REQ-029 After the wbuffer read, fill_valid_o SHALL be held at 1 until fill_ready_i.
REQ-030 S_WMISS with writeback: the fill handshake SHALL complete only in the same cycle as both aw_wren_o and w_wren_o, which requires !aw_afull_i && !w_afull_i.
REQ-031 Every wren/rden SHALL be a single-cycle pulse, and data outputs SHALL be stable while the matching valid/pending is asserted.
REQ-032 With NUM_WAYS=1, behaviour SHALL be a single-beat direct-mapped compare, and rr_ptr SHALL stay constant at 0.

Reset
REQ-033 While !rst_n, SHALL set state=S_IDLE, beat_cnt=0, rr_ptr=0 and all data registers=0.
REQ-034 While !rst_n, all outputs SHALL be 0, including the counters.
REQ-035 Reset mid-COLLECT SHALL abandon the request with no FIFO write; no partial pulse is allowed after reset.

Configuration
REQ-036 With macro TAG_CMP_STATS_EN defined, SHALL provide hit_cnt_o (output, 32) and miss_cnt_o (output, 32).
REQ-037 Under TAG_CMP_STATS_EN, each counter SHALL increment at resolution and saturate at 32'hFFFF_FFFF.
REQ-038 Without TAG_CMP_STATS_EN, SHALL omit these ports and counter logic entirely.

Structure
REQ-039 Package dcache_pkg SHALL hold the state enum and the tag field offsets (VALID_BIT, DIRTY_BIT, TAG_LSB/TAG_MSB).
REQ-040 One sub-module tag_way_match SHALL contain the combinational per-beat valid/tag compare and field extraction.

Verification
REQ-041 SHALL verify: NUM_WAYS=4, read with way 2 matching -> rob_wren_o 1 pulse, rob_data_o={tid, beat2 data}, no AR write.
REQ-042 SHALL verify: read miss with way 1 invalid, all others dirty -> ar_wren_o only, fill_way N/A, rr_ptr unchanged.
REQ-043 SHALL verify: read miss, all ways valid, rr_ptr=3 dirty -> ar/aw/w pulse same cycle, aw_data_o={way3 tag, idx, off}, rr_ptr wraps to 0.
REQ-044 SHALL verify: write hit way 0 with wbuf_aempty_i held high 5 cycles -> wbuf_rden_o after it drops, fill_way_o=0, fill_valid_o held under fill_ready_i=0 for 3 cycles.
REQ-045 SHALL verify: write miss with dirty victim and aw_afull_i=1 -> no fill handshake until aw_afull_i=0, then fill/aw/w complete in the same cycle.
REQ-046 SHALL verify: rst_n low at beat 2 of 4 -> no wren pulses, next request is processed from beat 0; with STATS_EN, counters are 0 after reset.
